// File: rtl/counter_inc_arbiter_if.sv
// Requester and counter-side signals of counter_inc_arbiter.
// The arbiter takes the slave view; producers and the counter take the master view.
interface counter_inc_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned AMT_W   = 4,
    parameter int unsigned TOT_W   = 8
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*AMT_W-1:0] req_amt;
    logic [NUM_REQ-1:0]       req_last;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     cnt_inc;
    logic [AMT_W-1:0]         cnt_amt;
    logic [TOT_W-1:0]         cnt_tot;

    modport master (
        output req_valid, req_amt, req_last, cnt_tot,
        input  req_ready, cnt_inc, cnt_amt
    );

    modport slave (
        input  req_valid, req_amt, req_last, cnt_tot,
        output req_ready, cnt_inc, cnt_amt
    );
endinterface

// File: rtl/counter_inc_arbiter.sv
// Round-robin, burst-owning arbiter issuing registered increments to a shared counter,
// with optional limit throttling. CNTARB_STATS_EN adds per-requester beat and stall counters.
module counter_inc_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned AMT_W     = 4,
    parameter int unsigned TOT_W     = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    counter_inc_arbiter_if.slave       bus,
    input  logic [TOT_W-1:0]           limit,
    input  logic                       limit_en,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       stalled
`ifdef CNTARB_STATS_EN
    ,
    output logic [NUM_REQ*8-1:0]       grant_cnt,
    output logic [15:0]                stall_cycles
`endif
);
    localparam int unsigned GW = $clog2(NUM_REQ);

    typedef enum logic [0:0] {StIdle, StOwn} state_e;

    state_e           state_q, state_d;
    logic [GW-1:0]    grant_q, grant_d;
    logic [3:0]       beat_q, beat_d;
    logic             rest_q, rest_d;
    logic             cnt_inc_q, cnt_inc_d;
    logic [AMT_W-1:0] cnt_amt_q, cnt_amt_d;

    logic             owner_valid;
    logic             owner_last;
    logic [AMT_W-1:0] owner_amt;
    logic [TOT_W:0]   shadow;
    logic [TOT_W:0]   need;
    logic             block;
    logic             xfer;
    logic             found;
    logic [3:0]       beat_inc;
    logic [NUM_REQ-1:0] ready;
    int unsigned      cand;

    // Shadow includes the increment still in flight so back-to-back beats see it.
    always_comb begin
        owner_valid = bus.req_valid[grant_q];
        owner_last  = bus.req_last[grant_q];
        owner_amt   = bus.req_amt[grant_q*AMT_W +: AMT_W];
        shadow      = {1'b0, bus.cnt_tot} + (cnt_inc_q ? (TOT_W+1)'(cnt_amt_q) : '0);
        need        = shadow + (TOT_W+1)'(owner_amt);
        block       = limit_en & owner_valid & (need > {1'b0, limit});
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        beat_d    = beat_q;
        rest_d    = rest_q;
        cnt_inc_d = 1'b0;
        cnt_amt_d = cnt_amt_q;
        ready     = '0;
        xfer      = 1'b0;
        found     = 1'b0;
        cand      = 0;
        beat_inc  = beat_q + 4'd1;
        unique case (state_q)
            StIdle: begin
                if (rest_q) begin
                    // Mandatory dead cycle after a release before re-arbitrating.
                    rest_d = 1'b0;
                end else begin
                    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
                        cand = (int'(grant_q) + i) % NUM_REQ;
                        if (!found && bus.req_valid[cand]) begin
                            found   = 1'b1;
                            grant_d = GW'(cand);
                        end
                    end
                    if (found) begin
                        state_d = StOwn;
                        beat_d  = '0;
                    end
                end
            end
            StOwn: begin
                ready[grant_q] = !block;
                xfer           = owner_valid & !block;
                if (xfer) begin
                    cnt_inc_d = 1'b1;
                    cnt_amt_d = owner_amt;
                    beat_d    = beat_inc;
                    if (owner_last || beat_inc == 4'(MAX_BURST)) begin
                        state_d = StIdle;
                        rest_d  = 1'b1;
                    end
                end else if (!owner_valid) begin
                    state_d = StIdle;
                    rest_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            grant_q   <= GW'(NUM_REQ - 1);
            beat_q    <= '0;
            rest_q    <= 1'b0;
            cnt_inc_q <= 1'b0;
            cnt_amt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            beat_q    <= beat_d;
            rest_q    <= rest_d;
            cnt_inc_q <= cnt_inc_d;
            cnt_amt_q <= cnt_amt_d;
        end
    end

    assign bus.req_ready = ready;
    assign bus.cnt_inc   = cnt_inc_q;
    assign bus.cnt_amt   = cnt_amt_q;
    assign grant_id      = grant_q;
    assign busy          = (state_q == StOwn);
    assign stalled       = (state_q == StOwn) & block;

`ifdef CNTARB_STATS_EN
    logic [NUM_REQ-1:0][7:0] grant_cnt_q, grant_cnt_d;
    logic [15:0]             stall_cycles_q, stall_cycles_d;

    always_comb begin
        grant_cnt_d    = grant_cnt_q;
        stall_cycles_d = stall_cycles_q;
        if (xfer && grant_cnt_q[grant_q] != 8'hFF) begin
            grant_cnt_d[grant_q] = grant_cnt_q[grant_q] + 8'd1;
        end
        if (stalled && stall_cycles_q != 16'hFFFF) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt_q    <= '0;
            stall_cycles_q <= '0;
        end else begin
            grant_cnt_q    <= grant_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign grant_cnt    = grant_cnt_q;
    assign stall_cycles = stall_cycles_q;
`endif
endmodule
